// File: rtl/zarb_pkg.sv
// Shared types and widths for the zarb multiplier and its multiply-accumulate wrapper.
package zarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int A_W = 3;
    localparam int B_W = 4;
    localparam int P_W = 7;

endpackage

// File: rtl/zarb.sv
// 3x4 unsigned array multiplier: AND-gate partial products reduced by two ripple rows.
module zarb
    import zarb_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    logic [B_W-1:0] pp0;
    logic [B_W-1:0] pp1;
    logic [B_W-1:0] pp2;
    logic [4:0]     row1;
    logic [4:0]     row2;

    assign pp0 = b & {B_W{a[0]}};
    assign pp1 = b & {B_W{a[1]}};
    assign pp2 = b & {B_W{a[2]}};

    // Each row retires its LSB as a product bit and passes the rest up one weight.
    assign row1 = {2'b00, pp0[3:1]} + {1'b0, pp1};
    assign row2 = {1'b0, row1[4:1]} + {1'b0, pp2};

    assign p = {row2, row1[0], pp0[0]};

endmodule

// File: rtl/zarb_mac.sv
// Multiply-accumulate stage: sums len products from zarb and presents the total on a valid/ready port.
module zarb_mac
    import zarb_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;
    logic [P_W-1:0]     prod;
    logic [ACC_W:0]     sum_ext;

    zarb u_zarb (
        .a (in_a),
        .b (in_b),
        .p (prod)
    );

    // Extra MSB of the widened add is the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - P_W){1'b0}}, prod};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake signals decode registered state only, so no ready/valid loops.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_zarb_mac.sv
// Bench for zarb_mac: a 12-bit and a 7-bit accumulator share stimulus and are checked against an arithmetic model.
module tb_zarb_mac;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [2:0]  in_a;
    logic [3:0]  in_b;
    logic        out_ready;

    logic        in_ready12, out_valid12, out_ovf12, busy12;
    logic [11:0] out_sum12;
    logic        in_ready7, out_valid7, out_ovf7, busy7;
    logic [6:0]  out_sum7;

    int nvec;
    int nmis;

    int ta [16];
    int tb [16];
    int tg [16];

    zarb_mac #(.ACC_W(12), .LEN_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready12), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid12), .out_ready(out_ready), .out_sum(out_sum12),
        .out_ovf(out_ovf12), .busy(busy12)
    );

    zarb_mac #(.ACC_W(7), .LEN_W(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready7), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid7), .out_ready(out_ready), .out_sum(out_sum7),
        .out_ovf(out_ovf7), .busy(busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_in_ready"},  32'(in_ready12),  0);
        chk({pfx, "_out_valid"}, 32'(out_valid12), 0);
        chk({pfx, "_busy"},      32'(busy12),      0);
        chk({pfx, "_busy7"},     32'(busy7),       0);
    endtask

    // One complete job: terms come from ta/tb, tg gives idle cycles before each term.
    task automatic run_job(input int n, input int hold, input bit rnd_start);
        int total;
        int e12, e7;
        bit o12, o7;
        total = 0;
        @(posedge clk); #1;
        start = 1'b1; len = 4'(n); out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; len = 4'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < tg[i]; g++) begin
                in_valid = 1'b0; in_a = 3'($urandom); in_b = 4'($urandom);
                start = rnd_start ? 1'($urandom) : 1'b0;
                @(negedge clk);
                chk("gap_in_ready", 32'(in_ready12), 1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_a = 3'(ta[i]); in_b = 4'(tb[i]);
            start = rnd_start ? 1'($urandom) : 1'b0;
            @(negedge clk);
            chk("acc_in_ready", 32'(in_ready12), 1);
            chk("acc_out_valid", 32'(out_valid12), 0);
            @(posedge clk); #1;
            total += ta[i] * tb[i];
            in_valid = 1'b0; start = 1'b0;
            in_a = 3'($urandom); in_b = 4'($urandom);
        end
        e12 = total % 4096; o12 = (total >= 4096);
        e7  = total % 128;  o7  = (total >= 128);
        @(negedge clk);
        chk("done_valid",  32'(out_valid12), 1);
        chk("done_valid7", 32'(out_valid7),  1);
        chk("done_ready",  32'(in_ready12),  0);
        chk("done_ready7", 32'(in_ready7),   0);
        chk("sum12", 32'(out_sum12), 32'(e12));
        chk("ovf12", 32'(out_ovf12), 32'(o12));
        chk("sum7",  32'(out_sum7),  32'(e7));
        chk("ovf7",  32'(out_ovf7),  32'(o7));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid12), 1);
            chk("hold_sum12", 32'(out_sum12), 32'(e12));
            chk("hold_sum7",  32'(out_sum7),  32'(e7));
            chk("hold_ovf7",  32'(out_ovf7),  32'(o7));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = rnd_start ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_idle("post");
    endtask

    initial begin
        nvec = 0; nmis = 0;
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;

        // Reset with random inputs toggling.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start = 1'($urandom); len = 4'($urandom); in_valid = 1'($urandom);
            in_a = 3'($urandom); in_b = 4'($urandom); out_ready = 1'($urandom);
        end
        @(negedge clk);
        chk_idle("rst");
        chk("rst_sum12", 32'(out_sum12), 0);
        chk("rst_ovf12", 32'(out_ovf12), 0);
        chk("rst_sum7",  32'(out_sum7),  0);
        chk("rst_ovf7",  32'(out_ovf7),  0);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("rel");

        // Basic sum: 105 + 1 + 0 = 106.
        ta[0] = 7; tb[0] = 15; tg[0] = 0;
        ta[1] = 1; tb[1] = 1;  tg[1] = 0;
        ta[2] = 0; tb[2] = 9;  tg[2] = 0;
        run_job(3, 0, 1'b0);

        // Backpressure: 12 + 10 = 22, gap of 3, result held 5 cycles.
        ta[0] = 3; tb[0] = 4; tg[0] = 0;
        ta[1] = 2; tb[1] = 5; tg[1] = 3;
        run_job(2, 5, 1'b0);

        // Zero length.
        run_job(0, 2, 1'b0);

        // Overflow in the 7-bit instance: 210 mod 128 = 82, then a clean run.
        ta[0] = 7; tb[0] = 15; tg[0] = 0;
        ta[1] = 7; tb[1] = 15; tg[1] = 0;
        run_job(2, 1, 1'b0);
        ta[0] = 1; tb[0] = 1; tg[0] = 0;
        run_job(1, 0, 1'b0);

        // Abort: start pulse mid-run is ignored, then async reset after 1 of 4 terms.
        @(posedge clk); #1;
        start = 1'b1; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 3'd5; in_b = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready12), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_sum12", 32'(out_sum12), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ta[0] = 3; tb[0] = 3; tg[0] = 1;
        ta[1] = 2; tb[1] = 7; tg[1] = 0;
        run_job(2, 1, 1'b0);

        // Randomized jobs, with stray start pulses during ACC and at the result handshake.
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                ta[i] = $urandom_range(0, 7);
                tb[i] = $urandom_range(0, 15);
                tg[i] = $urandom_range(0, 2);
            end
            run_job(n, $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/zarb_mac.md
# zarb_mac

Sequential multiply-accumulate stage placed directly downstream of the 3x4 array multiplier `zarb`. It accepts a programmed number of operand pairs over a valid/ready stream and feeds each pair through one `zarb` instance. It sums the 7-bit products into a wide accumulator and presents the total on a valid/ready result port. It turns the combinational multiplier into a dot-product engine for short 3-bit × 4-bit vectors.

## Interface
- `ACC_W`, default 12: accumulator and result width. Must be at least 7.
- `LEN_W`, default 4: width of the term-count input.
- `clk` input, 1: sole clock; all state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: begin a new accumulation. Sampled only in IDLE.
- `len` input, LEN_W: number of terms. Sampled together with `start`.
- `in_valid` input, 1: an operand pair is present.
- `in_ready` output, 1: the block will accept a pair this cycle.
- `in_a` input, 3: multiplier operand, unsigned.
- `in_b` input, 4: multiplicand, unsigned.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: downstream accepts the result.
- `out_sum` output, ACC_W: accumulated sum.
- `out_ovf` output, 1: sticky flag, set if any addition carried out of ACC_W.
- `busy` output, 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACC and DONE.
- **IDLE**
  - `in_ready`, `out_valid` and `busy` are 0.
  - On `start`, `acc` and `ovf` are cleared and `rem` is loaded with `len`.
  - If `len` is 0, the next state is DONE; otherwise it is ACC.
- **ACC**
  - `in_ready` is 1.
  - On a handshake (`in_valid & in_ready`):
    - `acc <= acc + zext(in_a*in_b)`;
    - `ovf <= ovf | carry`;
    - `rem <= rem - 1`.
  - A handshake when `rem` is 1 moves the FSM to DONE.
  - Cycles without a handshake hold all state.
- **DONE**
  - `out_valid` is 1; `out_sum` equals `acc` and `out_ovf` equals `ovf`.
  - Both outputs are held stable until `out_ready`.
  - On `out_ready`, the next state is IDLE.
- **Arithmetic**
  - Products are unsigned, 0..105, zero-extended to ACC_W.
  - The sum wraps modulo 2^ACC_W; the carry out of ACC_W sets `ovf`.
- **Ignored and edge cases**
  - `start` is ignored outside IDLE.
  - `in_valid` is ignored outside ACC.
  - `start` asserted together with `out_ready` in DONE: the start is dropped and the FSM returns to IDLE.
  - Reset mid-operation: the state returns to IDLE immediately and the partial sum is discarded.
- **Reset values:** state IDLE; `acc`, `rem`, `ovf` = 0; `in_ready`, `out_valid`, `busy`, `out_sum`, `out_ovf` all 0.

## Timing
- The multiplier is combinational between the input port and the accumulator adder. Product plus add is one register stage.
- Throughput is one term per cycle while `in_valid` is held high.
- Latency:
  - `start` in cycle 0 gives `in_ready` = 1 from cycle 1.
  - The N-th handshake in cycle k gives `out_valid` = 1 in cycle k+1.
- With `len` = 0, `out_valid` is 1 in the cycle after `start`.
- `in_ready` is a registered-state decode; it has no combinational path from `in_valid`.
- `out_valid` has no combinational path from `out_ready`.
- The earliest next `start` is accepted in the cycle after the result handshake.

## Structure
- Package `zarb_pkg` holds:
  - the state enum (IDLE=2'd0, ACC=2'd1, DONE=2'd2);
  - the operand widths A_W=3, B_W=4 and P_W=7.
- Sub-module: a single instance of the existing `zarb` multiplier, with `a` = `in_a`, `b` = `in_b` and the 7-bit product into the adder.
- The accumulator adder is a behavioural ACC_W+1-bit add; its MSB is the carry.

## Test plan
- **Reset:** assert `rst_n` = 0 with random inputs. Required: all outputs 0 and `busy` = 0. Release: still IDLE.
- **Basic sum:** `len` = 3 with pairs (7,15), (1,1), (0,9), back to back.
  - Required: `out_sum` = 106 and `out_ovf` = 0.
  - `out_valid` rises exactly one cycle after the third handshake.
- **Backpressure:** `len` = 2, pairs (3,4) and (2,5) with a 3-cycle `in_valid` gap between them, then hold `out_ready` = 0 for 5 cycles.
  - Required: `out_sum` = 22, held stable while `out_valid` = 1.
  - Returns to IDLE in the cycle after `out_ready` = 1.
- **Zero length:** `len` = 0.
  - Required: `out_valid` = 1 in the cycle after `start`, with `out_sum` = 0.
  - `in_ready` never asserts.
- **Overflow:** `ACC_W` = 7, `len` = 2, pairs (7,15) and (7,15).
  - Required: `out_sum` = 82 (210 mod 128) and `out_ovf` = 1.
  - The next run with `len` = 1 and pair (1,1) gives `out_ovf` = 0.
- **Abort and ignore:** pulse `start` during ACC; it must not restart the run. Then pull `rst_n` low after 1 of 4 terms.
  - Required: IDLE and `in_ready` = 0 immediately.
  - A fresh run afterwards returns the correct sum with no residue from the aborted run.
